writeback_arbiter: RTL

Write-back stage of the scoreboard datapath, directly downstream of the functional units.
- Captures each FU's completing result into a one-entry holding slot.
- Holds back results that the scoreboard flags as WAR hazards.
- Round-robin arbitrates eligible slots onto the single register-file write port.
- Notifies the scoreboard which FU retired, so it can clear that FU's status.

---
 rtl/scoreboard_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 21 ++
 rtl/writeback_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: shared scoreboard datapath defaults, FU indices, FU opcodes and round-robin helper
package scoreboard_pkg;
  localparam int NUM_FU_DEF = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int REG_BITS_DEF = 5;
  localparam int FU_BITS_DEF = 2;
  localparam int FU_ALU0 = 0;
  localparam int FU_ALU1 = 1;
  localparam int FU_MUL = 2;
  localparam int FU_DIV = 3;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  function automatic int rr_next(input int g, input int n);
    return (g + 1) % n;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, search starts at ptr; one-hot grant plus encoded index
module rr_arbiter import scoreboard_pkg::*; #(
  parameter int N = NUM_FU_DEF,
  parameter int IDX_BITS = FU_BITS_DEF
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [N-1:0]        gnt,
  output logic [IDX_BITS-1:0] idx,
  output logic                any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = |req;
    // walk backwards so the requester closest to ptr is written last and wins
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = IDX_BITS'((int'(ptr) + k) % N);
    if (any) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: per-FU holding slots, WAR hold-off and round-robin drain onto the single RF write port.
// Define WB_BYPASS_EN to let a result arriving at an empty, unblocked slot compete in its arrival cycle.
module writeback_arbiter import scoreboard_pkg::*; #(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int REG_BITS = REG_BITS_DEF,
  parameter int FU_BITS = FU_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_FU-1:0]            fu_result_valid,
  input  logic [NUM_FU*REG_BITS-1:0]   fu_result_reg,
  input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result_data,
  input  logic [NUM_FU-1:0]            war_block,
  output logic [NUM_FU-1:0]            slot_full,
  output logic                         rf_we,
  output logic [REG_BITS-1:0]          rf_waddr,
  output logic [DATA_WIDTH-1:0]        rf_wdata,
  output logic                         wb_valid,
  output logic [FU_BITS-1:0]           wb_fu_id,
  output logic                         overflow_err
);
  logic [NUM_FU-1:0] slot_valid_q, slot_valid_d, req, gnt, cap;
  logic [REG_BITS-1:0] slot_reg_q [NUM_FU];
  logic [DATA_WIDTH-1:0] slot_data_q [NUM_FU];
  logic [FU_BITS-1:0] ptr_q, gidx, fu_id_q;
  logic [REG_BITS-1:0] waddr_q, sel_reg;
  logic [DATA_WIDTH-1:0] wdata_q, sel_data;
  logic any, we_q, ovf_q, drop;
`ifdef WB_BYPASS_EN
  assign req = (slot_valid_q | fu_result_valid) & ~war_block;
`else
  assign req = slot_valid_q & ~war_block;
`endif
  rr_arbiter #(.N(NUM_FU), .IDX_BITS(FU_BITS)) u_rr (
    .req(req), .ptr(ptr_q), .gnt(gnt), .idx(gidx), .any(any)
  );
  // store when the slot is empty and not bypassed, or when it is full and draining this cycle
  assign cap = fu_result_valid & ~(slot_valid_q ^ gnt);
  assign slot_valid_d = cap | (slot_valid_q & ~gnt);
  assign drop = |(fu_result_valid & slot_valid_q & ~gnt);
  always_comb begin
    sel_reg = slot_valid_q[gidx] ? slot_reg_q[gidx] : fu_result_reg[int'(gidx)*REG_BITS +: REG_BITS];
    sel_data = slot_valid_q[gidx] ? slot_data_q[gidx] : fu_result_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        slot_reg_q[i] <= '0;
        slot_data_q[i] <= '0;
      end
      ptr_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      fu_id_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      for (int i = 0; i < NUM_FU; i++)
        if (cap[i]) begin
          slot_reg_q[i] <= fu_result_reg[i*REG_BITS +: REG_BITS];
          slot_data_q[i] <= fu_result_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      we_q <= any;
      if (any) begin
        waddr_q <= sel_reg;
        wdata_q <= sel_data;
        fu_id_q <= gidx;
        ptr_q <= FU_BITS'(rr_next(int'(gidx), NUM_FU));
      end
      ovf_q <= ovf_q | drop;
    end
  end
  assign slot_full = slot_valid_q;
  assign rf_we = we_q;
  assign wb_valid = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign wb_fu_id = fu_id_q;
  assign overflow_err = ovf_q;
endmodule
